strip_pingpong_sched: RTL and testbench
=======================================

Name: strip_pingpong_sched

Overview:
- Scheduler for the two 1280x16-pixel RGB strip buffers (ping-pong) in the image-to-DDR path.
- Tracks buffer fill status and tells the pixel writer which buffer to fill, or when to stall.
- For each full buffer, issues one DDR write command with a frame-relative address, then sequences beat-by-beat reads of that buffer to the DDR write-data port.
- Frees the buffer after the last beat, advances the strip index, and pulses frame completion every FRAME_STRIPS strips.

Parameters:
- BEATS_PER_STRIP, 960, DDR data beats per strip (1280*16*24 bits / 512).
- BEAT_BYTES, 64, bytes per DDR beat.
- FRAME_STRIPS, 45, strips per frame (720 lines / 16).
- ADDR_W, 32, DDR byte-address width.
- BASE_ADDR, 0, DDR byte address of strip 0.

Ports:
- clk_266  in  1  single clock for the whole block.
- rst_266  in  1  asynchronous, active-low reset.
- wr_done  in  1  1-cycle pulse: writer finished filling buffer wr_sel (already synchronous to clk_266).
- wr_sel  out  1  buffer the writer must fill next.
- wr_stall  out  1  high = buffer wr_sel is still full; writer must hold.
- cmd_valid  out  1  DDR write command valid.
- cmd_ready  in  1  DDR command accepted when both valid and ready are high.
- cmd_addr  out  ADDR_W  DDR byte address of the strip.
- cmd_len  out  16  beats in burst; constant BEATS_PER_STRIP.
- beat_ready  in  1  DDR write-data port can take a beat this cycle.
- rd_en  out  1  read one beat from buffer rd_buf at index rd_beat this cycle.
- rd_buf  out  1  buffer being drained.
- rd_beat  out  10  beat index, 0..BEATS_PER_STRIP-1.
- rd_last  out  1  rd_en for the final beat.
- strip_done  out  1  1-cycle pulse: strip drained, buffer freed.
- frame_done  out  1  1-cycle pulse, coincident with strip_done of the last strip.
- overflow  out  1  sticky error; cleared only by reset.

Behaviour:
Reset values:
- full[1:0]=00; wr_sel=0; rd_buf=0; state=IDLE.
- cmd_valid=0; cmd_addr=BASE_ADDR; rd_en=0; rd_beat=0; rd_last=0.
- strip_done=0; frame_done=0; overflow=0; strip_idx=0.
- Asserting reset mid-operation aborts any command or burst immediately. Nothing is retried.

Buffer status:
- wr_stall = full[wr_sel] (combinational).
- wr_done with full[wr_sel]=0: next cycle full[wr_sel]=1 and wr_sel toggles.
- wr_done with full[wr_sel]=1: pulse ignored; overflow<=1; wr_sel unchanged.
- Set and clear on different buffers in the same cycle both take effect.
- Set and clear on the same buffer in the same cycle: that wr_done is checked against pre-clear full, so it counts as overflow.

FSM (registered state):
- IDLE: if full[rd_buf], go to CMD and assert cmd_valid.
- CMD: cmd_valid=1. cmd_addr and cmd_len stay stable until cmd_ready. On the handshake, go to DATA and set rd_beat=0.
- DATA: rd_en = beat_ready (combinational). Each cycle with rd_en, rd_beat increments. rd_last = rd_en && rd_beat==BEATS_PER_STRIP-1. On rd_last, go to DONE.
- DONE (1 cycle):
  - full[rd_buf]<=0; rd_buf toggles; strip_done=1.
  - If strip_idx==FRAME_STRIPS-1: strip_idx<=0, cmd_addr<=BASE_ADDR, frame_done=1.
  - Otherwise: strip_idx+1, cmd_addr += BEATS_PER_STRIP*BEAT_BYTES (61440). Accumulator only, no multiplier.
  - Return to IDLE.

Latency:
- wr_done into an empty, idle block gives cmd_valid=1 two cycles later.
- With cmd_ready and beat_ready held high, a strip takes 1 (CMD) + 960 (DATA) + 1 (DONE) + 1 (IDLE) = 963 cycles from the first cmd_valid to the next cmd_valid.
- beat_ready low stalls rd_beat without losing position.

Arithmetic:
- cmd_addr wraps modulo 2^ADDR_W.
- rd_beat compares use full width; no wrap past BEATS_PER_STRIP-1.

Test Plan:
- Reset, one wr_done, cmd_ready=beat_ready=1 -> cmd_valid at +2 cycles with addr 0 and len 960. Exactly 960 rd_en on rd_buf=0, rd_last on beat 959, then strip_done. wr_sel=1, full=00.
- Two wr_done pulses 10 cycles apart, no ready -> wr_stall=1 after the second. A third wr_done sets overflow=1 and full stays 11. Then drain: buffer 0 at addr 0, then buffer 1 at addr 61440.
- cmd_ready held low 50 cycles -> cmd_valid and cmd_addr stable throughout. DATA starts on the cycle after the handshake.
- beat_ready toggling 1,0,1,0 -> rd_en mirrors beat_ready, rd_beat holds during 0, and total rd_en count is exactly 960.
- 45 consecutive strips -> frame_done pulses once, with strip 44 (addr 44*61440=2703360). Strip 45 is issued at addr 0.
- Reset asserted mid-DATA at beat 300 -> all outputs go to reset values asynchronously. After release, the next wr_done restarts at addr BASE_ADDR on buffer 0.

Source files
------------

// File: rtl/strip_pingpong_sched.sv
// Ping-pong strip buffer scheduler: tracks buffer fill state, issues one DDR write
// command per full strip and sequences the beat reads that drain it.
module strip_pingpong_sched #(
    parameter int unsigned       BEATS_PER_STRIP = 960,
    parameter int unsigned       BEAT_BYTES      = 64,
    parameter int unsigned       FRAME_STRIPS    = 45,
    parameter int unsigned       ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = '0
) (
    input  logic              clk_266,
    input  logic              rst_266,
    input  logic              wr_done,
    output logic              wr_sel,
    output logic              wr_stall,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [15:0]       cmd_len,
    input  logic              beat_ready,
    output logic              rd_en,
    output logic              rd_buf,
    output logic [9:0]        rd_beat,
    output logic              rd_last,
    output logic              strip_done,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned       IDX_W       = (FRAME_STRIPS > 1) ? $clog2(FRAME_STRIPS) : 1;
    localparam logic [9:0]        LAST_BEAT   = 10'(BEATS_PER_STRIP - 1);
    localparam logic [IDX_W-1:0]  LAST_STRIP  = IDX_W'(FRAME_STRIPS - 1);
    localparam logic [ADDR_W-1:0] STRIP_BYTES = ADDR_W'(BEATS_PER_STRIP * BEAT_BYTES);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t           state;
    logic [1:0]       full;
    logic [1:0]       full_next;
    logic [IDX_W-1:0] strip_idx;

    assign wr_stall = full[wr_sel];
    assign cmd_len  = 16'(BEATS_PER_STRIP);

    always_comb begin
        rd_en   = (state == DATA) && beat_ready;
        rd_last = rd_en && (rd_beat == LAST_BEAT);
    end

    // A set is qualified by the pre-clear full bit, so a fill landing on the buffer
    // being freed this cycle is still an overflow.
    always_comb begin
        full_next = full;
        if (state == DONE)
            full_next[rd_buf] = 1'b0;
        if (wr_done && !full[wr_sel])
            full_next[wr_sel] = 1'b1;
    end

    always_ff @(posedge clk_266 or negedge rst_266) begin
        if (!rst_266) begin
            state      <= IDLE;
            full       <= '0;
            wr_sel     <= 1'b0;
            rd_buf     <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_addr   <= BASE_ADDR;
            rd_beat    <= '0;
            strip_done <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            strip_idx  <= '0;
        end else begin
            strip_done <= 1'b0;
            frame_done <= 1'b0;
            full       <= full_next;
            if (wr_done) begin
                if (full[wr_sel])
                    overflow <= 1'b1;
                else
                    wr_sel <= ~wr_sel;
            end

            case (state)
                IDLE: begin
                    if (full[rd_buf]) begin
                        state     <= CMD;
                        cmd_valid <= 1'b1;
                    end
                end
                CMD: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= DATA;
                        cmd_valid <= 1'b0;
                        rd_beat   <= '0;
                    end
                end
                DATA: begin
                    if (rd_en) begin
                        if (rd_last) begin
                            rd_beat    <= '0;
                            state      <= DONE;
                            strip_done <= 1'b1;
                            frame_done <= (strip_idx == LAST_STRIP);
                        end else begin
                            rd_beat <= rd_beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    rd_buf <= ~rd_buf;
                    state  <= IDLE;
                    if (strip_idx == LAST_STRIP) begin
                        strip_idx <= '0;
                        cmd_addr  <= BASE_ADDR;
                    end else begin
                        strip_idx <= strip_idx + 1'b1;
                        cmd_addr  <= cmd_addr + STRIP_BYTES;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_strip_pingpong_sched.sv
// Directed bench for strip_pingpong_sched; expected commands are queued when a
// fill is reported and checked as each strip drains.
module tb_strip_pingpong_sched;

    logic        clk_266 = 1'b0;
    logic        rst_266 = 1'b0;
    logic        wr_done = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        beat_ready = 1'b0;
    logic        wr_sel, wr_stall, cmd_valid, rd_en, rd_buf, rd_last;
    logic        strip_done, frame_done, overflow;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [9:0]  rd_beat;

    strip_pingpong_sched #(
        .BEATS_PER_STRIP (960),
        .BEAT_BYTES      (64),
        .FRAME_STRIPS    (45),
        .ADDR_W          (32),
        .BASE_ADDR       (32'd0)
    ) dut (
        .clk_266    (clk_266),
        .rst_266    (rst_266),
        .wr_done    (wr_done),
        .wr_sel     (wr_sel),
        .wr_stall   (wr_stall),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .beat_ready (beat_ready),
        .rd_en      (rd_en),
        .rd_buf     (rd_buf),
        .rd_beat    (rd_beat),
        .rd_last    (rd_last),
        .strip_done (strip_done),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk_266 = ~clk_266;

    typedef struct {
        logic [31:0] addr;
        logic        bufsel;
        logic        frame;
    } sb_t;

    sb_t        sb[$];
    int         checks = 0;
    int         errors = 0;
    int         frame_pulses = 0;
    int         mstrip = 0;
    logic [1:0] mfull = 2'b00;
    logic       mwsel = 1'b0;
    logic       mover = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, {cmd_valid, rd_en, rd_last, strip_done, frame_done, overflow,
                  wr_sel, rd_buf, wr_stall, cmd_addr, rd_beat},
                 {9'b0, 32'd0, 10'd0});
    endtask

    task automatic do_reset();
        @(negedge clk_266);
        rst_266 = 1'b0; wr_done = 1'b0; cmd_ready = 1'b0; beat_ready = 1'b0;
        #1;
        chk_reset("reset_state");
        repeat (2) @(negedge clk_266);
        rst_266 = 1'b1;
        mfull = 2'b00; mwsel = 1'b0; mover = 1'b0; mstrip = 0;
        sb.delete();
    endtask

    task automatic pulse_wr();
        @(negedge clk_266);
        wr_done = 1'b1;
        #1;
        @(negedge clk_266);
        wr_done = 1'b0;
        if (mfull[mwsel]) begin
            mover = 1'b1;
        end else begin
            sb.push_back('{addr: 32'(mstrip * 61440), bufsel: mwsel, frame: (mstrip == 44)});
            mfull[mwsel] = 1'b1;
            mwsel = ~mwsel;
            mstrip = (mstrip + 1) % 45;
        end
        #1;
        chk("wr_sel", wr_sel, mwsel);
        chk("wr_stall", wr_stall, mfull[mwsel]);
        chk("overflow", overflow, mover);
    endtask

    task automatic drain(input int hold, input bit toggle);
        sb_t e;
        int  cyc, cnt, bufbad, beatbad, lastbad, mirbad, stbad;
        bit  sd, fd;
        chk("sb_nonempty", 64'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        cyc = 0;
        while (cmd_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk_266);
            cmd_ready = 1'b0; beat_ready = 1'b0;
            #1;
            cyc++;
        end
        chk("cmd_valid", cmd_valid, 1);
        chk("cmd_addr", cmd_addr, e.addr);
        chk("cmd_len", cmd_len, 960);
        stbad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_266);
            #1;
            if (cmd_valid !== 1'b1 || cmd_addr !== e.addr || rd_en !== 1'b0) stbad++;
        end
        if (hold > 0) chk("cmd_stable", stbad, 0);
        @(negedge clk_266);
        cmd_ready = 1'b1;
        #1;
        @(negedge clk_266);
        cmd_ready = 1'b0; beat_ready = 1'b1;
        #1;
        chk("data_start_valid", cmd_valid, 0);
        chk("data_start_rd_en", rd_en, 1);
        cnt = 0; bufbad = 0; beatbad = 0; lastbad = 0; mirbad = 0; sd = 0; fd = 0;
        for (cyc = 0; cyc < 4000 && !sd; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk_266);
                beat_ready = toggle ? (cyc % 2 == 0) : 1'b1;
                #1;
            end
            if (cnt < 960 && rd_en !== beat_ready) mirbad++;
            if (rd_en === 1'b1) begin
                if (rd_buf !== e.bufsel) bufbad++;
                if (rd_beat !== 10'(cnt)) beatbad++;
                if (rd_last !== (cnt == 959)) lastbad++;
                cnt++;
            end else if (rd_last !== 1'b0) begin
                lastbad++;
            end
            if (frame_done === 1'b1) frame_pulses++;
            if (strip_done === 1'b1) begin
                sd = 1;
                fd = frame_done;
            end
        end
        chk("strip_done_seen", sd, 1);
        chk("rd_en_count", cnt, 960);
        chk("rd_buf", bufbad, 0);
        chk("rd_beat_seq", beatbad, 0);
        chk("rd_last", lastbad, 0);
        chk("rd_en_mirror", mirbad, 0);
        chk("frame_done", fd, e.frame);
        mfull[e.bufsel] = 1'b0;
        @(negedge clk_266);
        beat_ready = 1'b0;
        #1;
        chk("strip_done_pulse", {strip_done, frame_done}, 2'b00);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        // Single strip: latency, address, length, beat sequence.
        do_reset();
        pulse_wr();
        chk("latency_plus1", cmd_valid, 0);
        @(negedge clk_266);
        #1;
        chk("latency_plus2", cmd_valid, 1);
        drain(0, 1'b0);
        chk("after_strip_wr_sel", wr_sel, 1);
        chk("after_strip_stall", wr_stall, 0);

        // Both buffers filled, third fill overflows, then drain in order.
        do_reset();
        pulse_wr();
        repeat (8) @(negedge clk_266);
        pulse_wr();
        chk("both_full_stall", wr_stall, 1);
        pulse_wr();
        chk("overflow_set", overflow, 1);
        chk("overflow_wr_sel", wr_sel, 0);
        drain(0, 1'b0);
        drain(0, 1'b0);
        chk("overflow_sticky", overflow, 1);

        // Command back-pressure, then beat back-pressure.
        pulse_wr();
        drain(50, 1'b0);
        pulse_wr();
        drain(0, 1'b1);

        // Full frame plus one strip to see the address wrap.
        do_reset();
        frame_pulses = 0;
        for (int s = 0; s < 46; s++) begin
            pulse_wr();
            drain(0, 1'b0);
            if (s == 44) chk("frame_pulses_45", frame_pulses, 1);
        end
        chk("frame_pulses_46", frame_pulses, 1);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        pulse_wr();
        cyc = 0;
        while (cmd_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk_266);
            #1;
            cyc++;
        end
        @(negedge clk_266);
        cmd_ready = 1'b1;
        @(negedge clk_266);
        cmd_ready = 1'b0; beat_ready = 1'b1;
        #1;
        cyc = 0;
        while (rd_beat !== 10'd300 && cyc < 400) begin
            @(negedge clk_266);
            #1;
            cyc++;
        end
        chk("reached_beat_300", rd_beat, 300);
        #2;
        rst_266 = 1'b0;
        #1;
        chk_reset("async_reset_mid_data");
        @(negedge clk_266);
        beat_ready = 1'b0;
        rst_266 = 1'b1;
        mfull = 2'b00; mwsel = 1'b0; mover = 1'b0; mstrip = 0;
        sb.delete();
        pulse_wr();
        drain(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
